// File: rtl/time_set_ctrl.sv
// Button-driven time setter: tracks live time in IDLE (1-cycle latency), edits captured time in HR/MIN/SEC.
// No backpressure: set/next are single-cycle pulses, inc/dec are levels turned into timed steps.
module time_set_ctrl #(
  parameter int unsigned MODE24      = 0,
  parameter int unsigned REPEAT_DLY  = 50000000,
  parameter int unsigned REPEAT_RATE = 10000000,
  parameter int unsigned TIMEOUT     = 500000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       set_i,
  input  logic       next_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [4:0] hours_i,
  input  logic [5:0] mins_i,
  input  logic [5:0] secs_i,
  input  logic       A_P_i,
  output logic [4:0] hours_o,
  output logic [5:0] mins_o,
  output logic [5:0] secs_o,
  output logic       A_P_o,
  output logic       load_o,
  output logic       editing_o,
  output logic [1:0] field_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HR   = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_t;

  localparam logic [31:0] DLY_C  = 32'(REPEAT_DLY);
  localparam logic [31:0] RATE_C = 32'(REPEAT_RATE);
  localparam logic [31:0] TO_C   = 32'(TIMEOUT);
  localparam logic [4:0]  HR_RST = (MODE24 != 0) ? 5'd0 : 5'd12;

  state_t      state;
  logic [4:0]  hr_q;
  logic [5:0]  min_q;
  logic [5:0]  sec_q;
  logic        ap_q;
  logic        load_q;
  logic [1:0]  btn_q;
  logic [31:0] rpt_cnt;
  logic        rpt_phase;
  logic [31:0] to_cnt;

  logic        one_btn;
  logic        btn_edge;
  logic        step_tick;
  logic        step;
  logic        activity;
  logic [4:0]  hr_nx;
  logic [5:0]  min_nx;
  logic [5:0]  sec_nx;
  logic        ap_nx;
  logic [4:0]  cap_hr;
  logic [5:0]  cap_min;
  logic [5:0]  cap_sec;

  // A change of the active button pattern (including inc<->dec swap) counts as a fresh press.
  assign one_btn   = inc_i ^ dec_i;
  assign btn_edge  = one_btn && ({inc_i, dec_i} != btn_q);
  assign step_tick = one_btn && !btn_edge && (rpt_cnt == (rpt_phase ? RATE_C : DLY_C));
  assign step      = btn_edge || step_tick;
  assign activity  = set_i || next_i || inc_i || dec_i;

  always_comb begin
    if (MODE24 != 0) begin
      cap_hr = (hours_i > 5'd23) ? 5'd0 : hours_i;
    end else begin
      cap_hr = ((hours_i == 5'd0) || (hours_i > 5'd12)) ? 5'd12 : hours_i;
    end
    cap_min = (mins_i > 6'd59) ? 6'd0 : mins_i;
    cap_sec = (secs_i > 6'd59) ? 6'd0 : secs_i;
  end

  // Per-field wrap; fields never carry into each other.
  always_comb begin
    hr_nx  = hr_q;
    min_nx = min_q;
    sec_nx = sec_q;
    ap_nx  = ap_q;
    case (state)
      S_HR: begin
        if (MODE24 != 0) begin
          if (inc_i) hr_nx = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
          else       hr_nx = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
        end else if (inc_i) begin
          if (hr_q == 5'd12) begin
            hr_nx = 5'd1;
          end else if (hr_q == 5'd11) begin
            hr_nx = 5'd12;
            ap_nx = ~ap_q;
          end else begin
            hr_nx = hr_q + 5'd1;
          end
        end else begin
          if (hr_q == 5'd12) begin
            hr_nx = 5'd11;
            ap_nx = ~ap_q;
          end else if (hr_q == 5'd1) begin
            hr_nx = 5'd12;
          end else begin
            hr_nx = hr_q - 5'd1;
          end
        end
      end
      S_MIN: begin
        if (inc_i) min_nx = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        else       min_nx = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      end
      S_SEC: begin
        if (inc_i) sec_nx = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        else       sec_nx = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      hr_q      <= HR_RST;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      ap_q      <= 1'b0;
      load_q    <= 1'b0;
      btn_q     <= 2'b00;
      rpt_cnt   <= 32'd0;
      rpt_phase <= 1'b0;
      to_cnt    <= 32'd0;
    end else begin
      btn_q  <= {inc_i, dec_i};
      load_q <= 1'b0;

      if (!one_btn || (state == S_IDLE) || set_i || next_i) begin
        rpt_cnt   <= 32'd0;
        rpt_phase <= 1'b0;
      end else if (btn_edge) begin
        rpt_cnt   <= 32'd1;
        rpt_phase <= 1'b0;
      end else if (step_tick) begin
        rpt_cnt   <= 32'd1;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 32'd1;
      end

      if (state == S_IDLE) begin
        to_cnt <= 32'd0;
        if (set_i) begin
          hr_q  <= cap_hr;
          min_q <= cap_min;
          sec_q <= cap_sec;
          ap_q  <= A_P_i;
          state <= S_HR;
        end else begin
          hr_q  <= hours_i;
          min_q <= mins_i;
          sec_q <= secs_i;
          ap_q  <= A_P_i;
        end
      end else begin
        if (set_i) begin
          load_q <= 1'b1;
          state  <= S_IDLE;
        end else if (next_i) begin
          case (state)
            S_HR:    state <= S_MIN;
            S_MIN:   state <= S_SEC;
            default: state <= S_HR;
          endcase
        end else if (step) begin
          hr_q  <= hr_nx;
          min_q <= min_nx;
          sec_q <= sec_nx;
          ap_q  <= ap_nx;
        end

        // Abandoned edit: return without a commit strobe; IDLE overwrites the edit values.
        if (activity) begin
          to_cnt <= 32'd0;
        end else if (to_cnt >= TO_C - 32'd1) begin
          to_cnt <= 32'd0;
          state  <= S_IDLE;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end
    end
  end

  assign hours_o   = hr_q;
  assign mins_o    = min_q;
  assign secs_o    = sec_q;
  assign A_P_o     = (MODE24 != 0) ? (hr_q >= 5'd12) : ap_q;
  assign load_o    = load_q;
  assign editing_o = (state != S_IDLE);
  assign field_o   = state;

endmodule
